hps_sw_poller: RTL and testbench

Avalon-MM master that periodically reads a 4-bit switch PIO input slave over its `s1` port and debounces the returned value. It publishes a stable switch state, a one-cycle change pulse, sticky per-bit edge flags and an interrupt for the control logic. It sits on the FPGA side of the HPS bridge and is the initiator paired with the switch PIO responder.

---
 rtl/hps_sw_poller.sv | 172 +++++++++++++++++
 tb/tb_hps_sw_poller.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_sw_poller.sv
// rtl/hps_sw_poller.sv - Avalon-MM poller and debouncer for a switch PIO slave
//
// Purpose: reads the switch PIO data register once per poll tick, debounces
// the returned value and publishes stable state, change pulse, sticky edge
// flags and an interrupt.
//
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   avm_*                Avalon-MM read master (address, read, waitrequest,
//                        readdata, readdatavalid)
//   enable               allows new polls to start
//   edge_clear           write-1-to-clear for edge_flags
//   sw_state             debounced switch value
//   sw_changed           one-cycle pulse when sw_state updates
//   edge_flags           sticky per-bit change flags, irq = |edge_flags
//   timeout_err          one-cycle pulse when a read is abandoned
//   busy                 high whenever a transaction is in progress
//
// TIMEOUT must be at least 2; POLL_DIV at least TIMEOUT+8.

module hps_sw_poller #(
    parameter int         WIDTH        = 4,
    parameter logic [1:0] SLAVE_ADDR   = 2'd0,
    parameter int         POLL_DIV     = 50000,
    parameter int         DEBOUNCE_CNT = 4,
    parameter int         TIMEOUT      = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       avm_address,
    output logic             avm_read,
    input  logic             avm_waitrequest,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_readdatavalid,
    input  logic             enable,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] sw_state,
    output logic             sw_changed,
    output logic [WIDTH-1:0] edge_flags,
    output logic             irq,
    output logic             timeout_err,
    output logic             busy
);

    localparam int TMR_W = $clog2(POLL_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_EVAL} state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic [WIDTH-1:0]   cand_q, cand_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   sw_state_q, sw_state_d;
    logic               sw_changed_q, sw_changed_d;
    logic [WIDTH-1:0]   edge_flags_q, edge_flags_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic               avm_read_q, avm_read_d;
    logic               tick;
    logic [WIDTH-1:0]   set_mask;

    // Only the low WIDTH bits of readdata carry switch information.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:WIDTH];

    always_comb begin
        tick          = (timer_q == '0);
        timer_d       = tick ? TMR_W'(POLL_DIV - 1) : timer_q - 1'b1;
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        sample_d      = sample_q;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        sw_state_d    = sw_state_q;
        sw_changed_d  = 1'b0;
        timeout_err_d = 1'b0;
        set_mask      = '0;

        case (state_q)
            S_IDLE: begin
                // Ticks seen in any other state are simply lost.
                if (tick && enable) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (avm_readdatavalid) begin
                    sample_d = avm_readdata[WIDTH-1:0];
                    state_d  = S_EVAL;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 2)) begin
                    // Counter lags the acceptance cycle by one, so the
                    // registered pulse lands TIMEOUT cycles after acceptance.
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_EVAL: begin
                if (sample_q != cand_q) begin
                    cand_d = sample_q;
                    cnt_d  = 4'd1;
                end else if (cnt_q < 4'(DEBOUNCE_CNT)) begin
                    cnt_d = cnt_q + 4'd1;
                end
                // Judged on the updated candidate so DEBOUNCE_CNT=1 accepts
                // a fresh sample immediately.
                if (cnt_d == 4'(DEBOUNCE_CNT) && cand_d != sw_state_q) begin
                    sw_state_d   = cand_d;
                    sw_changed_d = 1'b1;
                    set_mask     = cand_d ^ sw_state_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A set in the same cycle as a clear of that bit wins.
        edge_flags_d = (edge_flags_q & ~edge_clear) | set_mask;
        avm_read_d   = (state_d == S_REQ);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= TMR_W'(POLL_DIV - 1);
            to_cnt_q      <= '0;
            sample_q      <= '0;
            cand_q        <= '0;
            cnt_q         <= 4'd0;
            sw_state_q    <= '0;
            sw_changed_q  <= 1'b0;
            edge_flags_q  <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            avm_read_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            to_cnt_q      <= to_cnt_d;
            sample_q      <= sample_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            sw_state_q    <= sw_state_d;
            sw_changed_q  <= sw_changed_d;
            edge_flags_q  <= edge_flags_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            avm_read_q    <= avm_read_d;
        end
    end

    assign avm_address = SLAVE_ADDR;
    assign avm_read    = avm_read_q;
    assign sw_state    = sw_state_q;
    assign sw_changed  = sw_changed_q;
    assign edge_flags  = edge_flags_q;
    assign irq         = |edge_flags_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hps_sw_poller.sv
// tb/tb_hps_sw_poller.sv - self-checking bench for hps_sw_poller
module tb_hps_sw_poller;

    localparam int         PD   = 80;
    localparam int         DC   = 4;
    localparam int         TO   = 64;
    localparam logic [1:0] ADDR = 2'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b1;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        enable = 1'b1;
    logic [3:0]  edge_clear = 4'h0;
    logic [3:0]  sw_state;
    logic        sw_changed;
    logic [3:0]  edge_flags;
    logic        irq;
    logic        timeout_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: full sample history, expected outputs.
    logic [3:0] hist[$];
    logic [3:0] exp_state;
    logic [3:0] exp_edge;
    logic       exp_changed;

    hps_sw_poller #(
        .WIDTH(4), .SLAVE_ADDR(ADDR), .POLL_DIV(PD),
        .DEBOUNCE_CNT(DC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .enable(enable),
        .edge_clear(edge_clear), .sw_state(sw_state), .sw_changed(sw_changed),
        .edge_flags(edge_flags), .irq(irq), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        exp_state   = 4'h0;
        exp_edge    = 4'h0;
        exp_changed = 1'b0;
    endtask

    // A value is accepted once the last DC samples are identical and differ
    // from the published state.
    task automatic model_sample(input logic [3:0] v, input logic [3:0] clr);
        int run;
        logic [3:0] set;
        hist.push_back(v);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != v) break;
            run++;
        end
        set = 4'h0;
        exp_changed = 1'b0;
        if (run >= DC && v != exp_state) begin
            set = v ^ exp_state;
            exp_state = v;
            exp_changed = 1'b1;
        end
        exp_edge = (exp_edge & ~clr) | set;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_poll(input logic [31:0] data, input int wr, input int dly,
                           input bit respond, input logic [3:0] clr, input bit drop_en);
        int n;
        n = 0;
        while (avm_read !== 1'b1 && n < 3 * PD) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (avm_read !== 1'b1) begin
            errors++;
            $display("FAIL poll_request avm_read=%b expected 1", avm_read);
            return;
        end
        for (int i = 0; i < wr; i++) begin
            avm_waitrequest = 1'b1;
            checks++;
            if (avm_read !== 1'b1 || avm_address !== ADDR) begin
                errors++;
                $display("FAIL req_hold read=%b addr=%0d expected 1/%0d", avm_read, avm_address, ADDR);
            end
            @(negedge clk);
        end
        checks++;
        if (avm_read !== 1'b1 || avm_address !== ADDR || busy !== 1'b1) begin
            errors++;
            $display("FAIL req_accept read=%b addr=%0d busy=%b expected 1/%0d/1", avm_read, avm_address, busy, ADDR);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        if (drop_en) enable = 1'b0;
        checks++;
        if (avm_read !== 1'b0) begin
            errors++;
            $display("FAIL wait_read avm_read=%b expected 0", avm_read);
        end
        if (!respond) begin
            repeat (TO - 2) @(negedge clk);
            checks++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL timeout_early timeout_err=%b busy=%b expected 0/1", timeout_err, busy);
            end
            @(negedge clk);
            checks++;
            if (timeout_err !== 1'b1 || busy !== 1'b0 || sw_state !== exp_state) begin
                errors++;
                $display("FAIL timeout_pulse terr=%b busy=%b sw=%h expected 1/0/%h", timeout_err, busy, sw_state, exp_state);
            end
            @(negedge clk);
            checks++;
            if (timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_width timeout_err=%b expected 0", timeout_err);
            end
            return;
        end
        repeat (dly - 1) @(negedge clk);
        avm_readdatavalid = 1'b1;
        avm_readdata = data;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        edge_clear = clr;
        checks++;
        if (busy !== 1'b1 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL eval_cycle busy=%b sw_changed=%b expected 1/0", busy, sw_changed);
        end
        model_sample(data[3:0], clr);
        @(negedge clk);
        edge_clear = 4'h0;
        checks++;
        if (sw_state !== exp_state || sw_changed !== exp_changed || edge_flags !== exp_edge
            || irq !== (|exp_edge) || busy !== 1'b0) begin
            errors++;
            $display("FAIL eval_result sw=%h chg=%b edge=%h irq=%b busy=%b expected %h/%b/%h/%b/0",
                     sw_state, sw_changed, edge_flags, irq, busy, exp_state, exp_changed, exp_edge, |exp_edge);
        end
        @(negedge clk);
        checks++;
        if (sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL changed_width sw_changed=%b expected 0", sw_changed);
        end
    endtask

    task automatic do_clear(input logic [3:0] c);
        @(negedge clk);
        edge_clear = c;
        @(negedge clk);
        edge_clear = 4'h0;
        exp_edge = exp_edge & ~c;
        checks++;
        if (edge_flags !== exp_edge || irq !== (|exp_edge)) begin
            errors++;
            $display("FAIL edge_clear edge=%h irq=%b expected %h/%b", edge_flags, irq, exp_edge, |exp_edge);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (avm_read !== 1'b0 || avm_address !== ADDR || sw_state !== 4'h0 || sw_changed !== 1'b0
            || edge_flags !== 4'h0 || irq !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values read=%b addr=%0d sw=%h chg=%b edge=%h irq=%b terr=%b busy=%b expected 0/%0d/0/0/0/0/0/0",
                     avm_read, avm_address, sw_state, sw_changed, edge_flags, irq, timeout_err, busy, ADDR);
        end
    endtask

    task automatic test_steady();
        int n;
        do_reset();
        n = 0;
        while (avm_read !== 1'b1 && n < 3 * PD) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != PD) begin
            errors++;
            $display("FAIL first_tick_latency cycles=%0d expected %0d", n, PD);
        end
        for (int i = 0; i < 4; i++) begin
            do_poll({$urandom, 4'h5} >> 0 & 32'hFFFF_FFF5 | 32'h5, 0, 1, 1'b1, 4'h0, 1'b0);
            checks++;
            if (sw_state !== (i == 3 ? 4'h5 : 4'h0)) begin
                errors++;
                $display("FAIL steady_poll%0d sw_state=%h expected %h", i, sw_state, (i == 3 ? 4'h5 : 4'h0));
            end
        end
        checks++;
        if (edge_flags !== 4'h5 || irq !== 1'b1) begin
            errors++;
            $display("FAIL steady_edges edge=%h irq=%b expected 5/1", edge_flags, irq);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [6];
        seq = '{4'h5, 4'h0, 4'h5, 4'h5, 4'h5, 4'h5};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_poll({28'h0, seq[i]}, 0, 2, 1'b1, 4'h0, 1'b0);
            checks++;
            if (sw_state !== (i == 5 ? 4'h5 : 4'h0)) begin
                errors++;
                $display("FAIL bounce_sample%0d sw_state=%h expected %h", i, sw_state, (i == 5 ? 4'h5 : 4'h0));
            end
        end
    endtask

    task automatic test_waitrequest();
        do_reset();
        for (int i = 0; i < 4; i++) do_poll(32'hABCD_0005, 7, 1, 1'b1, 4'h0, 1'b0);
        checks++;
        if (sw_state !== 4'h5 || edge_flags !== 4'h5) begin
            errors++;
            $display("FAIL waitreq_result sw=%h edge=%h expected 5/5", sw_state, edge_flags);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) do_poll(32'h0000_000A, 0, 1, 1'b1, 4'h0, 1'b0);
        do_poll(32'h0, 0, 1, 1'b0, 4'h0, 1'b0);
        do_poll(32'h0000_000A, 0, 3, 1'b1, 4'h0, 1'b0);
        checks++;
        if (sw_state !== 4'hA) begin
            errors++;
            $display("FAIL timeout_keeps_count sw_state=%h expected a", sw_state);
        end
    endtask

    task automatic test_edge_clear();
        do_reset();
        for (int i = 0; i < 4; i++) do_poll(32'h5, 0, 1, 1'b1, 4'h0, 1'b0);
        do_clear(4'h5);
        for (int i = 0; i < 4; i++) do_poll(32'h4, 0, 1, 1'b1, (i == 3) ? 4'h1 : 4'h0, 1'b0);
        checks++;
        if (edge_flags !== 4'h1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear edge=%h irq=%b expected 1/1", edge_flags, irq);
        end
        do_clear(4'h5);
    endtask

    task automatic test_enable_drop();
        int seen;
        do_poll(32'h7, 0, 2, 1'b1, 4'h0, 1'b1);
        seen = 0;
        repeat (2 * PD) begin
            @(negedge clk);
            if (avm_read === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL enable_drop active_cycles=%0d expected 0", seen);
        end
        enable = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic [3:0] c;
        v = 4'h0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 9) < 4) v = 4'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            do_poll({28'($urandom), v}, $urandom_range(0, 3), $urandom_range(1, 4), 1'b1, c, 1'b0);
            if ($urandom_range(0, 4) == 0) do_clear(4'($urandom));
        end
    endtask

    task automatic test_reset_midflight();
        int n;
        int bad;
        n = 0;
        while (avm_read !== 1'b1 && n < 3 * PD) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checks++;
        if (avm_read !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset read=%b busy=%b expected 0/0", avm_read, busy);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (avm_read !== 1'b1 && n < 3 * PD) begin
            @(negedge clk);
            n++;
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'hFFFF_FFFF;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        bad = 0;
        repeat (2 * PD) begin
            @(negedge clk);
            if (avm_read !== 1'b0 || busy !== 1'b0 || sw_state !== 4'h0 || sw_changed !== 1'b0
                || edge_flags !== 4'h0 || irq !== 1'b0 || timeout_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_in_wait nonreset_cycles=%0d expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_bounce();
        test_waitrequest();
        test_timeout();
        test_edge_clear();
        test_enable_drop();
        test_random();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
